// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one combinational FP32 multiplier among NUM_REQ requesters,
// with a fixed-latency result pipeline and a credit-protected in-order result FIFO.
// Optional feature: define FPMUL_ARB_ZERO_BYPASS_EN to force zero-exponent products to signed zero.

module mult (
    output logic [31:0] out,
    input  logic [31:0] a,
    input  logic [31:0] b
);
    logic [47:0] mant_s;
    logic [7:0]  exp_s;
    logic        mant_unused_s;

    // Truncating multiply; every operand is treated as normal (implicit leading one).
    always_comb begin
        mant_s = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        exp_s  = a[30:23] + b[30:23] - 8'd127;
        if (mant_s[47]) begin
            out = {a[31] ^ b[31], exp_s + 8'd1, mant_s[46:24]};
        end else begin
            out = {a[31] ^ b[31], exp_s, mant_s[45:23]};
        end
    end

    assign mant_unused_s = ^mant_s[22:0];
endmodule

module fpmul_arbiter #(
    parameter int  NUM_REQ  = 4,
    parameter int  PIPE_LAT = 2,
    localparam int IDW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);
    localparam int DEPTH = PIPE_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [IDW-1:0]               last_q, last_d;
    logic [NUM_REQ-1:0]           grant_s;
    logic [IDW-1:0]               gidx_s;
    logic                         hit_s, can_issue_s, accept_s, pop_s, push_s;
    logic [CW-1:0]                out_q, out_d;
    logic [CW-1:0]                fcnt_q, fcnt_d;
    logic [31:0]                  a_sel_s, b_sel_s, prod_raw_s, prod_s;
    logic [PIPE_LAT-1:0]          stg_vld_q, stg_vld_d;
    logic [PIPE_LAT-1:0][31:0]    stg_data_q, stg_data_d;
    logic [PIPE_LAT-1:0][IDW-1:0] stg_id_q, stg_id_d;
    logic [DEPTH-1:0][31:0]       mem_data_q, mem_data_d;
    logic [DEPTH-1:0][IDW-1:0]    mem_id_q, mem_id_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!hit_s && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                grant_s[(int'(last_q) + k) % NUM_REQ] = 1'b1;
                gidx_s = IDW'((int'(last_q) + k) % NUM_REQ);
                hit_s  = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Credits cover pipeline plus FIFO, so a granted operation always has a FIFO slot.
    assign can_issue_s = (out_q < CW'(DEPTH));
    assign req_ready   = rst_n ? (grant_s & {NUM_REQ{can_issue_s}}) : '0;
    assign accept_s    = |(req_valid & req_ready);
    assign rsp_valid   = (fcnt_q != '0);
    assign pop_s       = rsp_valid & rsp_ready;
    assign push_s      = stg_vld_q[PIPE_LAT-1];
    assign a_sel_s     = req_a[{gidx_s, 5'd0} +: 32];
    assign b_sel_s     = req_b[{gidx_s, 5'd0} +: 32];

    mult u_mult (
        .out (prod_raw_s),
        .a   (a_sel_s),
        .b   (b_sel_s)
    );

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    always_comb begin
        if ((a_sel_s[30:23] == 8'd0) || (b_sel_s[30:23] == 8'd0)) begin
            prod_s = {a_sel_s[31] ^ b_sel_s[31], 31'd0};
        end else begin
            prod_s = prod_raw_s;
        end
    end
`else
    assign prod_s = prod_raw_s;
`endif

    always_comb begin
        if (accept_s) begin
            last_d = gidx_s;
        end else begin
            last_d = last_q;
        end
        out_d  = out_q + CW'(accept_s) - CW'(pop_s);
        fcnt_d = fcnt_q + CW'(push_s) - CW'(pop_s);

        stg_vld_d[0]  = accept_s;
        stg_data_d[0] = prod_s;
        stg_id_d[0]   = gidx_s;
        for (int s = 1; s < PIPE_LAT; s++) begin
            stg_vld_d[s]  = stg_vld_q[s-1];
            stg_data_d[s] = stg_data_q[s-1];
            stg_id_d[s]   = stg_id_q[s-1];
        end

        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        if (push_s) begin
            mem_data_d[wr_ptr_q] = stg_data_q[PIPE_LAT-1];
            mem_id_d[wr_ptr_q]   = stg_id_q[PIPE_LAT-1];
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Reset discards everything in flight or buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= IDW'(NUM_REQ - 1);
            out_q      <= '0;
            fcnt_q     <= '0;
            stg_vld_q  <= '0;
            stg_data_q <= '0;
            stg_id_q   <= '0;
            mem_data_q <= '0;
            mem_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            last_q     <= last_d;
            out_q      <= out_d;
            fcnt_q     <= fcnt_d;
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            stg_id_q   <= stg_id_d;
            mem_data_q <= mem_data_d;
            mem_id_q   <= mem_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign rsp_data = mem_data_q[rd_ptr_q];
    assign rsp_id   = mem_id_q[rd_ptr_q];
    assign busy     = (out_q != '0);
endmodule
